// File: rtl/i2c_pkg.sv
// Shared types for the I2C byte master: FSM states, SCL quarter phases, bus drive decode.
package i2c_pkg;

   localparam int unsigned SCL_QUARTER_DEFAULT = 250;

   typedef enum logic [2:0] {
      IDLE, START, DATA, ACK, DONE, HOLD, RSTART, STOP
   } state_t;

   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_t;

   typedef struct packed {
      logic scl;
      logic sda_low;
   } bus_drive_t;

   // Bus levels wanted for a state/phase; sda_low=1 pulls SDA down, 0 releases it.
   function automatic bus_drive_t bus_drive(state_t s, phase_t p, logic data_bit);
      bus_drive_t d;
      d = '{scl: 1'b1, sda_low: 1'b0};
      case (s)
         IDLE:    d = '{scl: 1'b1, sda_low: 1'b0};
         START:   d = '{scl: 1'b1, sda_low: 1'b1};
         DATA:    d = '{scl: (p == Q2) || (p == Q3), sda_low: !data_bit};
         ACK:     d = '{scl: (p == Q2) || (p == Q3), sda_low: 1'b0};
         DONE:    d = '{scl: 1'b0, sda_low: 1'b0};
         HOLD:    d = '{scl: 1'b0, sda_low: 1'b1};
         RSTART:  d = '{scl: (p == Q1), sda_low: 1'b0};
         STOP:    d = '{scl: (p != Q0), sda_low: (p == Q0) || (p == Q1)};
         default: d = '{scl: 1'b1, sda_low: 1'b0};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Local command handshake between a host and the I2C byte master.
interface i2c_master_if;
   logic [7:0] tx_data;
   logic       start;
   logic       stop;
   logic       i2c_en;
   logic       ready;
   logic       tx_done;

   modport master (input tx_data, start, stop, i2c_en, output ready, tx_done);
   modport slave  (output tx_data, start, stop, i2c_en, input ready, tx_done);
endinterface

// File: rtl/i2c_scl_tick.sv
// Quarter-SCL-period counter and phase generator; idles at Q0 while disabled.
module i2c_scl_tick
   import i2c_pkg::*;
#(
   parameter int unsigned SCL_QUARTER = SCL_QUARTER_DEFAULT
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   input  logic   restart,
   output phase_t phase,
   output logic   wrap_c
);

   localparam int unsigned CW = (SCL_QUARTER > 2) ? $clog2(SCL_QUARTER) : 1;

   logic [CW-1:0] cnt;

   assign wrap_c = en && (cnt == CW'(SCL_QUARTER - 1));

   // restart forces the next phase back to Q0 for states shorter than a full bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         phase <= Q0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= Q0;
      end else if (wrap_c) begin
         cnt   <= '0;
         phase <= restart ? Q0 : phase_t'(2'(phase + 2'd1));
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C byte transmitter with START / repeated START / STOP generation.
// Optional: define I2C_MASTER_ACK_CHECK_EN to turn a NACK into an automatic STOP.
module i2c_master
   import i2c_pkg::*;
#(
   parameter int unsigned SCL_QUARTER = SCL_QUARTER_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   i2c_master_if.master        cmd,
   output logic                SCL,
   inout  wire                 SDA
);

   state_t     state;
   phase_t     phase;
   logic       wrap_c;
   logic       tick_en_c;
   logic       last_q_c;
   logic       accept_c;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic       sda_pre;
   logic       sda_low;
   bus_drive_t drive_c;
`ifdef I2C_MASTER_ACK_CHECK_EN
   logic       nack;
`endif

   assign tick_en_c = state inside {START, DATA, ACK, RSTART, STOP};
   assign last_q_c  = wrap_c && (((state == START || state == RSTART) && phase == Q1)
                                 || phase == Q3);
   assign accept_c  = cmd.ready && cmd.i2c_en;
   assign drive_c   = bus_drive(state, phase, shreg[7]);

   i2c_scl_tick #(.SCL_QUARTER(SCL_QUARTER)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .en      (tick_en_c),
      .restart (last_q_c),
      .phase   (phase),
      .wrap_c  (wrap_c)
   );

   // SDA trails SCL by one clock so data edges always land while SCL is low
   assign SDA = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         SCL         <= 1'b1;
         sda_pre     <= 1'b0;
         sda_low     <= 1'b0;
         cmd.ready   <= 1'b1;
         cmd.tx_done <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
         nack        <= 1'b0;
`endif
      end else begin
         cmd.tx_done <= 1'b0;
         SCL         <= drive_c.scl;
         sda_pre     <= drive_c.sda_low;
         sda_low     <= sda_pre;
         case (state)
            IDLE: begin
               if (accept_c && !cmd.stop && cmd.start) begin
                  state     <= START;
                  shreg     <= cmd.tx_data;
                  bit_cnt   <= 3'd7;
                  cmd.ready <= 1'b0;
               end
            end
            HOLD: begin
               if (accept_c) begin
                  shreg     <= cmd.tx_data;
                  bit_cnt   <= 3'd7;
                  cmd.ready <= 1'b0;
                  if (cmd.stop)       state <= STOP;
                  else if (cmd.start) state <= RSTART;
                  else                state <= DATA;
               end
            end
            RSTART: if (last_q_c) state <= START;
            START:  if (last_q_c) state <= DATA;
            DATA: begin
               if (last_q_c) begin
                  if (bit_cnt == 3'd0) begin
                     state <= ACK;
                  end else begin
                     bit_cnt <= bit_cnt - 3'd1;
                     shreg   <= {shreg[6:0], 1'b0};
                  end
               end
            end
            ACK: begin
`ifdef I2C_MASTER_ACK_CHECK_EN
               if (wrap_c && phase == Q2) nack <= SDA;
`endif
               if (last_q_c) begin
                  state       <= DONE;
                  cmd.tx_done <= 1'b1;
               end
            end
            DONE: begin
`ifdef I2C_MASTER_ACK_CHECK_EN
               if (nack) begin
                  state <= STOP;
               end else begin
                  state     <= HOLD;
                  cmd.ready <= 1'b1;
               end
`else
               state     <= HOLD;
               cmd.ready <= 1'b1;
`endif
            end
            STOP: begin
               if (last_q_c) begin
                  state     <= IDLE;
                  cmd.ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: slave BFM on SCL/SDA feeds an event scoreboard.
`timescale 1ns/1ps
module tb_i2c_master;

   localparam int QC       = 4;
   localparam int TIMEOUT  = 2000;
   localparam int EV_BYTE  = 32'h100;
   localparam int EV_START = 32'h200;
   localparam int EV_STOP  = 32'h300;

   logic clk = 1'b0;
   logic reset;
   wire  SCL;
   wire  SDA;
   logic ack_drive;
   logic ack_en;
   int   checks = 0;
   int   failures = 0;
   int   exp_q[$];
   int   obs_q[$];

   i2c_master_if cmd ();

   i2c_master #(.SCL_QUARTER(QC)) dut (
      .clk   (clk),
      .reset (reset),
      .cmd   (cmd),
      .SCL   (SCL),
      .SDA   (SDA)
   );

   pullup (SDA);
   assign SDA = ack_drive ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   // Slave BFM: reports START/STOP/byte events and ACKs when ack_en is set
   initial begin : slave_bfm
      logic       scl_q, sda_q;
      int         bitn;
      logic [7:0] sh;
      ack_drive = 1'b0;
      scl_q = 1'b1; sda_q = 1'b1; bitn = 0; sh = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            ack_drive = 1'b0;
            bitn = 0;
         end else if (scl_q && SCL && sda_q && !SDA) begin
            obs_q.push_back(EV_START);
            bitn = 0;
         end else if (scl_q && SCL && !sda_q && SDA) begin
            obs_q.push_back(EV_STOP);
            bitn = 0;
         end else if (!scl_q && SCL) begin
            if (bitn < 8) begin
               sh = {sh[6:0], SDA};
               bitn++;
               if (bitn == 8) obs_q.push_back(EV_BYTE | int'(sh));
            end else if (bitn == 8) begin
               bitn = 9;
            end
         end else if (scl_q && !SCL) begin
            if (bitn == 8) ack_drive = ack_en;
            else if (bitn == 9) begin
               ack_drive = 1'b0;
               bitn = 0;
            end
         end
         scl_q = SCL;
         sda_q = SDA;
      end
   end

   // Presents a command and returns once it has been taken by a clock edge
   task automatic issue(input logic s, input logic p, input logic [7:0] d,
                        input logic keep, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      cmd.start = s; cmd.stop = p; cmd.tx_data = d; cmd.i2c_en = 1'b1;
      for (int n = 0; n < TIMEOUT; n++) begin
         if (cmd.ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      if (!keep) cmd.i2c_en = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok = 1'b0;
      for (int n = 0; n < TIMEOUT; n++) begin
         @(negedge clk);
         if (cmd.tx_done) begin
            ok = 1'b1;
            break;
         end
         cyc++;
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < TIMEOUT; n++) begin
         @(negedge clk);
         if (cmd.ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (SCL !== 1'b1) begin failures++; $display("FAIL reset_scl got=%b want=1", SCL); end
      checks++; if (SDA !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b want=1", SDA); end
      checks++; if (cmd.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", cmd.ready); end
      checks++; if (cmd.tx_done !== 1'b0) begin failures++; $display("FAIL reset_tx_done got=%b want=0", cmd.tx_done); end
   endtask

   task automatic test_start_byte();
      bit ok; int cyc, e, o;
      exp_q.push_back(EV_START);
      exp_q.push_back(EV_BYTE | 32'hAA);
      issue(1'b1, 1'b0, 8'hAA, 1'b0, ok);
      @(negedge clk);
      checks++; if (cmd.ready !== 1'b0) begin failures++; $display("FAIL start_ready_fall got=%b want=0", cmd.ready); end
      wait_done(cyc, ok);
      cyc++;
      checks++; if (!ok) begin failures++; $display("FAIL start_done_timeout got=none want=tx_done"); end
      checks++; if (cyc < 38*QC || cyc > 38*QC+2) begin failures++; $display("FAIL start_latency got=%0d want=%0d..%0d", cyc, 38*QC, 38*QC+2); end
      checks++; if (cmd.ready !== 1'b0) begin failures++; $display("FAIL start_ready_at_done got=%b want=0", cmd.ready); end
      @(negedge clk);
      checks++; if (cmd.tx_done !== 1'b0) begin failures++; $display("FAIL start_done_pulse got=%b want=0", cmd.tx_done); end
      checks++; if (cmd.ready !== 1'b1) begin failures++; $display("FAIL start_ready_rise got=%b want=1", cmd.ready); end
      repeat (3) @(negedge clk);
      checks++; if ({SCL, SDA} !== 2'b00) begin failures++; $display("FAIL hold_bus got=%b%b want=00", SCL, SDA); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL start_event got=none want=%h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL start_event got=%h want=%h", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL start_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_byte_only();
      bit ok; int cyc, e, o;
      exp_q.push_back(EV_BYTE | 32'hFF);
      issue(1'b0, 1'b0, 8'hFF, 1'b0, ok);
      wait_done(cyc, ok);
      cyc++;
      checks++; if (!ok) begin failures++; $display("FAIL byte_done_timeout got=none want=tx_done"); end
      checks++; if (cyc < 36*QC || cyc > 36*QC+2) begin failures++; $display("FAIL byte_latency got=%0d want=%0d..%0d", cyc, 36*QC, 36*QC+2); end
      @(negedge clk);
      checks++; if (cmd.ready !== 1'b1) begin failures++; $display("FAIL byte_hold_ready got=%b want=1", cmd.ready); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL byte_event got=none want=%h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL byte_event got=%h want=%h", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL byte_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_repeated_start();
      bit ok; int cyc, e, o;
      exp_q.push_back(EV_START);
      exp_q.push_back(EV_BYTE | 32'h3C);
      issue(1'b1, 1'b0, 8'h3C, 1'b0, ok);
      wait_done(cyc, ok);
      cyc++;
      checks++; if (!ok) begin failures++; $display("FAIL rstart_done_timeout got=none want=tx_done"); end
      checks++; if (cyc < 40*QC || cyc > 40*QC+2) begin failures++; $display("FAIL rstart_latency got=%0d want=%0d..%0d", cyc, 40*QC, 40*QC+2); end
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL rstart_event got=none want=%h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL rstart_event got=%h want=%h", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rstart_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_back_to_back();
      bit ok; int cyc, e, o;
      exp_q.push_back(EV_BYTE | 32'h81);
      exp_q.push_back(EV_BYTE | 32'h7E);
      issue(1'b0, 1'b0, 8'h81, 1'b1, ok);
      @(negedge clk);
      cmd.tx_data = 8'h7E;
      wait_done(cyc, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_done1_timeout got=none want=tx_done"); end
      @(negedge clk);
      checks++; if (cmd.ready !== 1'b1) begin failures++; $display("FAIL b2b_first_hold got=%b want=1", cmd.ready); end
      @(negedge clk);
      checks++; if (cmd.ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b want=0", cmd.ready); end
      cmd.i2c_en = 1'b0;
      wait_done(cyc, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_done2_timeout got=none want=tx_done"); end
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL b2b_event got=none want=%h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL b2b_event got=%h want=%h", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_stop();
      bit ok; int e, o;
      exp_q.push_back(EV_STOP);
      issue(1'b0, 1'b1, 8'h00, 1'b0, ok);
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL stop_timeout got=busy want=ready"); end
      checks++; if ({SCL, SDA} !== 2'b11) begin failures++; $display("FAIL stop_idle_bus got=%b%b want=11", SCL, SDA); end
      @(negedge clk);
      checks++; if (cmd.tx_done !== 1'b0) begin failures++; $display("FAIL stop_tx_done got=%b want=0", cmd.tx_done); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL stop_event got=none want=%h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL stop_event got=%h want=%h", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stop_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_idle_ignore();
      bit ok;
      issue(1'b0, 1'b1, 8'h12, 1'b0, ok);
      @(negedge clk);
      checks++; if (cmd.ready !== 1'b1) begin failures++; $display("FAIL idle_stop_ready got=%b want=1", cmd.ready); end
      issue(1'b0, 1'b0, 8'h34, 1'b0, ok);
      @(negedge clk);
      checks++; if (cmd.ready !== 1'b1) begin failures++; $display("FAIL idle_byte_ready got=%b want=1", cmd.ready); end
      repeat (20) @(negedge clk);
      checks++; if ({SCL, SDA} !== 2'b11) begin failures++; $display("FAIL idle_bus got=%b%b want=11", SCL, SDA); end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL idle_events got=%0d want=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_nack();
      bit ok; int cyc, e, o;
      ack_en = 1'b0;
      exp_q.push_back(EV_START);
      exp_q.push_back(EV_BYTE | 32'h5A);
      exp_q.push_back(EV_STOP);
      issue(1'b1, 1'b0, 8'h5A, 1'b0, ok);
      wait_done(cyc, ok);
      checks++; if (!ok) begin failures++; $display("FAIL nack_done_timeout got=none want=tx_done"); end
      @(negedge clk);
`ifdef I2C_MASTER_ACK_CHECK_EN
      checks++; if (cmd.ready !== 1'b0) begin failures++; $display("FAIL nack_ready_low got=%b want=0", cmd.ready); end
`else
      checks++; if (cmd.ready !== 1'b1) begin failures++; $display("FAIL nack_ignored_hold got=%b want=1", cmd.ready); end
      issue(1'b0, 1'b1, 8'h00, 1'b0, ok);
`endif
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL nack_idle_timeout got=busy want=ready"); end
      checks++; if ({SCL, SDA} !== 2'b11) begin failures++; $display("FAIL nack_idle_bus got=%b%b want=11", SCL, SDA); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL nack_event got=none want=%h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL nack_event got=%h want=%h", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL nack_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
      ack_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      issue(1'b1, 1'b0, 8'h00, 1'b0, ok);
      repeat (2*QC + 3) @(negedge clk);
      checks++; if ({SCL, SDA} !== 2'b00) begin failures++; $display("FAIL mid_pre_bus got=%b%b want=00", SCL, SDA); end
      reset = 1'b1;
      #1;
      checks++; if ({SCL, SDA} !== 2'b11) begin failures++; $display("FAIL mid_reset_bus got=%b%b want=11", SCL, SDA); end
      checks++; if (cmd.ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b want=1", cmd.ready); end
      @(negedge clk);
      #2;
      reset = 1'b0;
      obs_q.delete();
      @(negedge clk);
      checks++; if (cmd.tx_done !== 1'b0) begin failures++; $display("FAIL mid_reset_tx_done got=%b want=0", cmd.tx_done); end
   endtask

   initial begin
      reset = 1'b1;
      ack_en = 1'b1;
      cmd.i2c_en = 1'b0;
      cmd.start = 1'b0;
      cmd.stop = 1'b0;
      cmd.tx_data = 8'h00;
      test_reset();
      test_start_byte();
      test_byte_only();
      test_repeated_start();
      test_back_to_back();
      test_stop();
      test_idle_ignore();
      test_nack();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
